// File: rtl/demux_1to2_stream_if.sv
// Valid/ready bundle for the 1-to-2 stream demux: one input stream and two output streams.
// The master side is the producer/consumer environment, the slave side is the demux.
interface demux_1to2_stream_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          sel;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [DW-1:0] out1_data;

  modport master (
    output in_valid, in_data, sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_data, sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux_1to2_stream.sv
// 1-to-2 valid/ready demux with a one-entry register slice per output.
// Optional per-output delivered-beat counters are built when DEMUX_CNT_EN is defined.
module demux_1to2_stream #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_1to2_stream_if.slave   bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     out0_cnt,
  output logic [CNT_W-1:0]     out1_cnt
);

  logic          v0_q, v0_d;
  logic          v1_q, v1_d;
  logic [DW-1:0] d0_q, d0_d;
  logic [DW-1:0] d1_q, d1_d;
  logic          free0_s, free1_s;
  logic          xfer_s, load0_s, load1_s;
  logic          drain0_s, drain1_s;

  // A slice is free when empty or when its current beat leaves this cycle.
  assign free0_s  = !v0_q || bus.out0_ready;
  assign free1_s  = !v1_q || bus.out1_ready;
  assign drain0_s = v0_q && bus.out0_ready;
  assign drain1_s = v1_q && bus.out1_ready;

  assign bus.in_ready = bus.sel ? free1_s : free0_s;
  assign xfer_s       = bus.in_valid && bus.in_ready;
  assign load0_s      = xfer_s && !bus.sel;
  assign load1_s      = xfer_s && bus.sel;

  // Slice next-state: a load wins over a drain so a same-cycle drain+load keeps valid high.
  always_comb begin
    v0_d = v0_q;
    d0_d = d0_q;
    v1_d = v1_q;
    d1_d = d1_q;
    if (load0_s) begin
      v0_d = 1'b1;
      d0_d = bus.in_data;
    end else if (drain0_s) begin
      v0_d = 1'b0;
    end else begin
      v0_d = v0_q;
    end
    if (load1_s) begin
      v1_d = 1'b1;
      d1_d = bus.in_data;
    end else if (drain1_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
  end

  // Slice registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
    end
  end

  assign bus.out0_valid = v0_q;
  assign bus.out0_data  = d0_q;
  assign bus.out1_valid = v1_q;
  assign bus.out1_data  = d1_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counter next-state: clear dominates, increments wrap naturally.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cnt_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      cnt0_d = drain0_s ? cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt0_q;
      cnt1_d = drain1_s ? cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt1_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign out0_cnt = cnt0_q;
  assign out1_cnt = cnt1_q;
`else
  logic unused_cnt_clr_s;

  assign unused_cnt_clr_s = cnt_clr;
  assign out0_cnt         = '0;
  assign out1_cnt         = '0;
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed self-checking bench for demux_1to2_stream (counter checks depend on DEMUX_CNT_EN).
module tb_demux_1to2_stream;
  localparam int DW    = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cnt_clr;
  logic [CNT_W-1:0] out0_cnt;
  logic [CNT_W-1:0] out1_cnt;
  int               n_chk;
  int               n_fail;

  demux_1to2_stream_if #(.DW(DW)) bus ();

  demux_1to2_stream #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .cnt_clr  (cnt_clr),
    .out0_cnt (out0_cnt),
    .out1_cnt (out1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.sel      = s;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    cnt_clr = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.sel        = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;

    // 1. reset
    repeat (3) step();
    chk("rst_v0", {31'd0, bus.out0_valid}, 32'd0);
    chk("rst_v1", {31'd0, bus.out1_valid}, 32'd0);
    chk("rst_d0", {24'd0, bus.out0_data}, 32'd0);
    chk("rst_d1", {24'd0, bus.out1_data}, 32'd0);
    chk("rst_rdy_sel0", {31'd0, bus.in_ready}, 32'd1);
    bus.sel = 1'b1;
    #1;
    chk("rst_rdy_sel1", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_cnt0", {28'd0, out0_cnt}, 32'd0);
    chk("rst_cnt1", {28'd0, out1_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // 2. routing
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    send(8'hA5, 1'b0);
    #1;
    chk("rt_rdy0", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("rt_v0", {31'd0, bus.out0_valid}, 32'd1);
    chk("rt_d0", {24'd0, bus.out0_data}, 32'h0A5);
    chk("rt_v1_idle", {31'd0, bus.out1_valid}, 32'd0);
    send(8'h3C, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("rt_v1", {31'd0, bus.out1_valid}, 32'd1);
    chk("rt_d1", {24'd0, bus.out1_data}, 32'h03C);
    chk("rt_v0_drained", {31'd0, bus.out0_valid}, 32'd0);
    step();
    chk("rt_v1_drained", {31'd0, bus.out1_valid}, 32'd0);

    // 3. stall isolation
    bus.out0_ready = 1'b0;
    send(8'h11, 1'b0);
    step();
    chk("st_v0", {31'd0, bus.out0_valid}, 32'd1);
    chk("st_d0", {24'd0, bus.out0_data}, 32'h011);
    send(8'h22, 1'b1);
    #1;
    chk("st_rdy1", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("st_v1", {31'd0, bus.out1_valid}, 32'd1);
    chk("st_d1", {24'd0, bus.out1_data}, 32'h022);
    send(8'h33, 1'b0);
    #1;
    chk("st_rdy0_blocked", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("st_hold_v0", {31'd0, bus.out0_valid}, 32'd1);
    chk("st_hold_d0", {24'd0, bus.out0_data}, 32'h011);
    chk("st_still_blocked", {31'd0, bus.in_ready}, 32'd0);
    bus.out0_ready = 1'b1;
    #1;
    chk("st_rdy0_freed", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("st_replace_v0", {31'd0, bus.out0_valid}, 32'd1);
    chk("st_replace_d0", {24'd0, bus.out0_data}, 32'h033);
    step();
    chk("st_v0_drained", {31'd0, bus.out0_valid}, 32'd0);

    // 4. back-to-back alternating
    for (int i = 0; i < 16; i++) begin
      send(i[7:0], i[0]);
      #1;
      chk("b2b_rdy", {31'd0, bus.in_ready}, 32'd1);
      step();
      if (i[0] == 1'b0) begin
        chk("b2b_v0", {31'd0, bus.out0_valid}, 32'd1);
        chk("b2b_d0", {24'd0, bus.out0_data}, i);
        chk("b2b_v1_drained", {31'd0, bus.out1_valid}, 32'd0);
      end else begin
        chk("b2b_v1", {31'd0, bus.out1_valid}, 32'd1);
        chk("b2b_d1", {24'd0, bus.out1_data}, i);
        chk("b2b_v0_drained", {31'd0, bus.out0_valid}, 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    step();

    // 5. mid-flight reset
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    send(8'hAA, 1'b0);
    step();
    send(8'hBB, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("mr_full_v0", {31'd0, bus.out0_valid}, 32'd1);
    chk("mr_full_v1", {31'd0, bus.out1_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_async_v0", {31'd0, bus.out0_valid}, 32'd0);
    chk("mr_async_v1", {31'd0, bus.out1_valid}, 32'd0);
    chk("mr_async_d0", {24'd0, bus.out0_data}, 32'd0);
    step();
    rst_n = 1'b1;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    step();
    step();
    chk("mr_post_v0", {31'd0, bus.out0_valid}, 32'd0);
    chk("mr_post_v1", {31'd0, bus.out1_valid}, 32'd0);

    // 6. counters
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cnt_clr0", {28'd0, out0_cnt}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      send(i[7:0] + 8'h40, 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
`ifdef DEMUX_CNT_EN
    chk("cnt1_wrap", {28'd0, out1_cnt}, 32'd1);
`else
    chk("cnt1_tied", {28'd0, out1_cnt}, 32'd0);
`endif
    chk("cnt0_quiet", {28'd0, out0_cnt}, 32'd0);
    send(8'h77, 1'b1);
    step();
    bus.in_valid = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cnt1_clr_prio", {28'd0, out1_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
